// File: rtl/sound_sequencer_if.sv
// Game-FSM to sound sequencer link.
// Master requests melodies, slave drives speaker/status.
interface sound_sequencer_if;
  logic       enable_sound;
  logic [9:0] sound_freq_in;
  logic       stop;
  logic       audio_out;
  logic       busy;
  logic       done;
  logic [1:0] note_idx;

  modport master (
    output enable_sound,
    output sound_freq_in,
    output stop,
    input  audio_out,
    input  busy,
    input  done,
    input  note_idx
  );

  modport slave (
    input  enable_sound,
    input  sound_freq_in,
    input  stop,
    output audio_out,
    output busy,
    output done,
    output note_idx
  );
endinterface

// File: rtl/sound_sequencer.sv
// Three-note win/lose melody player.
// Square wave per note, silent gaps, done pulse.
module sound_sequencer #(
  parameter int unsigned NOTE_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 2500000,
  parameter int unsigned HP_L0       = 47801,
  parameter int unsigned HP_L1       = 63776,
  parameter int unsigned HP_L2       = 95602,
  parameter int unsigned HP_W0       = 47801,
  parameter int unsigned HP_W1       = 37936,
  parameter int unsigned HP_W2       = 31888
) (
  input logic              clk,
  input logic              resetN,
  sound_sequencer_if.slave bus
);

  function automatic int unsigned max2(
    int unsigned a,
    int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned HP_MAX =
    max2(max2(max2(HP_L0, HP_L1), HP_L2),
         max2(max2(HP_W0, HP_W1), HP_W2));

  localparam int NW = $clog2(NOTE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam int HW = $clog2(HP_MAX + 1);

  localparam logic [NW-1:0] NOTE_LAST =
    NW'(NOTE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam bit NO_GAP = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE,
    TONE,
    GAP,
    FINISH
  } state_t;

  state_t        state;
  logic          en_d;
  logic          mel;
  logic [1:0]    note_idx;
  logic [NW-1:0] note_cnt;
  logic [GW-1:0] gap_cnt;
  logic [HW-1:0] hp_cnt;
  logic [HW-1:0] hp_last;
  logic          audio_q;
  logic          busy_q;
  logic          done_q;
  logic          start;
  logic          sel_ok;

  assign start  = bus.enable_sound & ~en_d;
  assign sel_ok = ~|bus.sound_freq_in[9:1];

  assign bus.audio_out = audio_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.note_idx  = note_idx;

  always_comb begin
    hp_last = HW'(HP_L0 - 1);
    case ({mel, note_idx})
      3'b0_00: hp_last = HW'(HP_L0 - 1);
      3'b0_01: hp_last = HW'(HP_L1 - 1);
      3'b0_10: hp_last = HW'(HP_L2 - 1);
      3'b1_00: hp_last = HW'(HP_W0 - 1);
      3'b1_01: hp_last = HW'(HP_W1 - 1);
      3'b1_10: hp_last = HW'(HP_W2 - 1);
      default: hp_last = HW'(HP_L0 - 1);
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      en_d     <= 1'b0;
      mel      <= 1'b0;
      note_idx <= '0;
      note_cnt <= '0;
      gap_cnt  <= '0;
      hp_cnt   <= '0;
      audio_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      en_d <= bus.enable_sound;
      if (bus.stop) begin
        state    <= IDLE;
        note_idx <= '0;
        note_cnt <= '0;
        gap_cnt  <= '0;
        hp_cnt   <= '0;
        audio_q  <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && sel_ok) begin
              state    <= TONE;
              mel      <= bus.sound_freq_in[0];
              note_idx <= '0;
              note_cnt <= '0;
              hp_cnt   <= '0;
              audio_q  <= 1'b0;
              busy_q   <= 1'b1;
            end
          end
          TONE: begin
            if (note_cnt == NOTE_LAST) begin
              note_cnt <= '0;
              hp_cnt   <= '0;
              audio_q  <= 1'b0;
              if (note_idx == 2'd2) begin
                state  <= FINISH;
                done_q <= 1'b1;
              end else if (NO_GAP) begin
                // back-to-back notes, stay in TONE
                note_idx <= note_idx + 2'd1;
              end else begin
                state   <= GAP;
                gap_cnt <= '0;
              end
            end else begin
              note_cnt <= note_cnt + NW'(1);
              if (hp_cnt == hp_last) begin
                hp_cnt  <= '0;
                audio_q <= ~audio_q;
              end else begin
                hp_cnt <= hp_cnt + HW'(1);
              end
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state    <= TONE;
              gap_cnt  <= '0;
              note_idx <= note_idx + 2'd1;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          FINISH: begin
            state    <= IDLE;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            note_idx <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench for sound_sequencer.
// Expected traces come from a timeline model.
module tb_sound_sequencer;

  logic clk = 1'b0;
  logic resetN;
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt;

  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  sound_sequencer_if sif();

  sound_sequencer #(
    .NOTE_CYCLES(8),
    .GAP_CYCLES (2),
    .HP_L0      (2),
    .HP_L1      (2),
    .HP_L2      (2),
    .HP_W0      (1),
    .HP_W1      (2),
    .HP_W2      (4)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (sif.slave)
  );

  task automatic chk(
    string       tag,
    logic [31:0] got,
    logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] outs();
    return {sif.busy, sif.audio_out, sif.done,
            sif.note_idx};
  endfunction

  // {busy,audio,done,note_idx}, j = cycles after start edge
  function automatic logic [4:0] exp_at(
    bit mel,
    int j
  );
    int n;
    int t;
    int h;
    logic a;
    if (j >= 29) return 5'd0;
    if (j == 28) return {1'b1, 1'b0, 1'b1, 2'd2};
    n = j / 10;
    t = j % 10;
    if (t >= 8) return {1'b1, 1'b0, 1'b0, 2'(n)};
    if (mel) h = (n == 0) ? 1 : ((n == 1) ? 2 : 4);
    else h = 2;
    a = ((t / h) % 2) == 1;
    return {1'b1, a, 1'b0, 2'(n)};
  endfunction

  task automatic push_mel(
    bit mel,
    int n,
    int cut
  );
    for (int j = 0; j < n; j++) begin
      if (cut >= 0 && j >= cut) exp_q.push_back(5'd0);
      else exp_q.push_back(exp_at(mel, j));
    end
  endtask

  task automatic push_idle(int n);
    for (int j = 0; j < n; j++) exp_q.push_back(5'd0);
  endtask

  task automatic step(string tag);
    logic [4:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(outs()), 32'(e));
    end
    if (sif.done) done_cnt++;
  endtask

  initial begin
    resetN            = 1'b0;
    sif.enable_sound  = 1'b0;
    sif.sound_freq_in = 10'd0;
    sif.stop          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 0);
    @(negedge clk);
    resetN = 1'b1;
    push_idle(2);
    repeat (2) step("idle");

    // win melody, enable held 40 cycles
    done_cnt          = 0;
    sif.sound_freq_in = 10'd1;
    sif.enable_sound  = 1'b1;
    push_mel(1, 40, -1);
    repeat (40) step("win");
    chk("win_done", done_cnt, 1);
    sif.enable_sound = 1'b0;
    push_idle(2);
    repeat (2) step("win_tail");

    // lose melody, single-cycle pulse
    done_cnt          = 0;
    sif.sound_freq_in = 10'd0;
    sif.enable_sound  = 1'b1;
    push_mel(0, 35, -1);
    step("lose");
    sif.enable_sound = 1'b0;
    repeat (34) step("lose");
    chk("lose_done", done_cnt, 1);

    // invalid select
    sif.sound_freq_in = 10'd5;
    sif.enable_sound  = 1'b1;
    push_idle(10);
    repeat (10) step("invalid");
    sif.enable_sound = 1'b0;
    push_idle(2);
    repeat (2) step("invalid");

    // abort at cycle 12 of a win melody
    done_cnt          = 0;
    sif.sound_freq_in = 10'd1;
    sif.enable_sound  = 1'b1;
    push_mel(1, 35, 12);
    for (int j = 0; j < 35; j++) begin
      if (j == 12) sif.stop = 1'b1;
      step("abort");
      if (j == 0) sif.enable_sound = 1'b0;
      if (j == 12) sif.stop = 1'b0;
    end
    chk("abort_nodone", done_cnt, 0);
    done_cnt         = 0;
    sif.enable_sound = 1'b1;
    push_mel(1, 32, -1);
    step("restart");
    sif.enable_sound = 1'b0;
    repeat (31) step("restart");
    chk("restart_done", done_cnt, 1);

    // start and stop together, then retrigger attempt
    sif.enable_sound = 1'b1;
    sif.stop         = 1'b1;
    push_idle(5);
    step("collide");
    sif.stop = 1'b0;
    repeat (4) step("collide");
    sif.enable_sound = 1'b0;
    push_idle(1);
    step("collide");
    done_cnt         = 0;
    sif.enable_sound = 1'b1;
    push_mel(1, 32, -1);
    for (int j = 0; j < 32; j++) begin
      step("retrig");
      if (j == 0) sif.enable_sound = 1'b0;
      if (j == 12) sif.enable_sound = 1'b1;
      if (j == 13) sif.enable_sound = 1'b0;
    end
    chk("retrig_done", done_cnt, 1);

    // async reset mid-TONE, release with enable high
    sif.sound_freq_in = 10'd0;
    sif.enable_sound  = 1'b1;
    push_mel(0, 4, -1);
    repeat (4) step("pre_rst");
    #2;
    resetN = 1'b0;
    #1;
    chk("rst_async", 32'(outs()), 0);
    @(negedge clk);
    resetN   = 1'b1;
    done_cnt = 0;
    push_mel(0, 32, -1);
    repeat (32) step("post_rst");
    chk("post_rst_done", done_cnt, 1);
    sif.enable_sound = 1'b0;

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
